// File: rtl/result_drain_arbiter.sv
`default_nettype none
// ============================================================================
// result_drain_arbiter : round-robin drain of full per-engine result FIFOs
//                        into one tagged valid/ready stream.
// Revision 1.0
// ============================================================================
module result_drain_arbiter #(
    parameter  int BLOCK_COUNT = 25,
    parameter  int K           = 128,
    parameter  int N           = 32,
    localparam int CW          = $clog2(N) + 1,
    localparam int BW          = $clog2(BLOCK_COUNT)
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESETN,
    input  logic                      start,
    input  logic [15:0]               batch_total,
    input  logic [BLOCK_COUNT*CW-1:0] rd_cnt,
    input  logic [BLOCK_COUNT*K-1:0]  rd_dout,
    output logic [BLOCK_COUNT-1:0]    rd_rdy,
    output logic [K-1:0]              m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic [BW-1:0]             m_blk,
    output logic                      busy,
    output logic                      finished,
    output logic [15:0]               batch_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [BW-1:0]            rr_ptr_q, sel_q, hit_idx;
    logic [CW-1:0]            word_cnt_q;
    logic [15:0]              total_q;
    logic [BLOCK_COUNT-1:0]   full;
    logic [2*BLOCK_COUNT-1:0] full2;
    logic [K-1:0]             dout_a [BLOCK_COUNT];
    logic [BW:0]              off, sum;
    logic                     hit, pop, accept, last_accept;

    for (genvar b = 0; b < BLOCK_COUNT; b++) begin : g_blk
        assign full[b]   = rd_cnt[b*CW +: CW] >= CW'(N);
        assign dout_a[b] = rd_dout[b*K +: K];
    end

    // Rotate so rr_ptr lands at bit 0; the lowest set bit is the winner.
    always_comb begin
        full2 = {full, full} >> rr_ptr_q;
        hit   = |full2[BLOCK_COUNT-1:0];
        off   = '0;
        for (int j = BLOCK_COUNT - 1; j >= 0; j--) begin
            if (full2[j]) off = (BW+1)'(j);
        end
        sum     = {1'b0, rr_ptr_q} + off;
        hit_idx = (sum >= (BW+1)'(BLOCK_COUNT)) ? BW'(sum - (BW+1)'(BLOCK_COUNT))
                                                : sum[BW-1:0];
    end

    assign accept      = m_valid && m_ready;
    assign last_accept = accept && m_last;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (batch_total == 16'd0) ? S_DONE : S_SCAN;
            S_SCAN:  if (hit) state_d = S_DRAIN;
            S_DRAIN: if (last_accept)
                         state_d = ((batch_cnt + 16'd1) == total_q) ? S_DONE : S_SCAN;
            default: state_d = S_IDLE;
        endcase
    end

    // Pop only while words remain and the output register is free or draining.
    always_comb begin
        pop         = (state_q == S_DRAIN) && (word_cnt_q < CW'(N)) && (!m_valid || m_ready);
        rd_rdy      = '0;
        rd_rdy[sel_q] = pop;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            word_cnt_q <= '0;
            total_q    <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_blk      <= '0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            batch_cnt  <= '0;
        end else begin
            finished <= (state_q == S_DONE);
            if (state_q == S_DONE) busy <= 1'b0;
            if (state_q == S_IDLE && start) begin
                total_q   <= batch_total;
                batch_cnt <= '0;
                busy      <= 1'b1;
            end
            if (state_q == S_SCAN && hit) begin
                sel_q      <= hit_idx;
                word_cnt_q <= '0;
            end
            if (pop) begin
                m_data     <= dout_a[sel_q];
                m_blk      <= sel_q;
                m_valid    <= 1'b1;
                m_last     <= (word_cnt_q == CW'(N - 1));
                word_cnt_q <= word_cnt_q + CW'(1);
            end else if (accept) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            if (last_accept) begin
                batch_cnt <= batch_cnt + 16'd1;
                rr_ptr_q  <= (sel_q == BW'(BLOCK_COUNT - 1)) ? '0 : sel_q + BW'(1);
            end
        end
    end

endmodule
`default_nettype wire
